lcd_read_controller: RTL and testbench
======================================

// Module: lcd_read_controller
// PURPOSE
//  Read-side companion to the LCD write path: runs HD44780-style read cycles
//  (rw=1) on the character LCD bus. Supports a single status read (busy flag +
//  address counter, rs=0), a single DDRAM/CGRAM data read (rs=1), and a
//  poll-until-not-busy sequence with timeout. Sits beside the write controller;
//  the top level muxes lcd_rs/lcd_rw/lcd_e with bus_own and tri-states the data bus.
// PARAMETERS
//  T_AS      2  clk cycles of rs/rw setup before lcd_e rises (>=1)
//  T_PW      5  clk cycles lcd_e held high (>=1)
//  T_H       2  clk cycles rs/rw held after lcd_e falls (>=1)
//  T_GAP     4  idle clk cycles between poll reads, bus_own held (>=1)
//  POLL_MAX  8  max status reads in one poll op (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous reset, active-low
//  req          in   1  start request, sampled only in IDLE
//  op           in   2  00 status read, 01 data read, 10 poll busy, 11 = 00
//  busy         out  1  high from accept cycle+1 until done pulse inclusive
//  done         out  1  one-cycle completion pulse
//  rd_data      out  8  last sampled bus byte, held until next sample
//  busy_flag    out  1  rd_data[7]
//  addr_cnt     out  7  rd_data[6:0]
//  timeout      out  1  valid with done: poll ended with BF still 1
//  bus_own      out  1  high while this block drives lcd_rs/lcd_rw/lcd_e
//  lcd_rs       out  1  register select
//  lcd_rw       out  1  1 = read
//  lcd_e        out  1  enable strobe
//  lcd_data_in  in   8  LCD data bus (input path)
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; busy, done, timeout, bus_own, lcd_rs, lcd_rw,
//   lcd_e = 0; rd_data = 8'h00; counters cleared. lcd_e falls in the same instant.
//  All outputs registered. States: IDLE, SETUP, E_HIGH, HOLD, GAP, DONE.
//  IDLE: req=1 at edge N -> latch op; SETUP from N+1. req outside IDLE ignored.
//  SETUP (T_AS cyc): bus_own=1, lcd_rw=1, lcd_rs=(op==01), lcd_e=0.
//  E_HIGH (T_PW cyc): lcd_e=1. lcd_data_in registered into rd_data at the edge
//   ending the last E_HIGH cycle (same edge lcd_e goes 0).
//  HOLD (T_H cyc): lcd_e=0, rs/rw held. Then:
//   op 00/01/11 -> DONE.
//   op 10: rd_data[7]=0 -> DONE, timeout=0; rd_data[7]=1 and reads < POLL_MAX
//   -> GAP (lcd_rw=1, lcd_e=0, bus_own=1) for T_GAP cyc, then SETUP;
//   rd_data[7]=1 and reads == POLL_MAX -> DONE, timeout=1.
//  DONE (1 cyc): done=1, busy=1, bus_own=0, lcd_rw=0, lcd_rs=0; next IDLE.
//   timeout valid only while done=1, else 0.
//  Single-read latency: done high T_AS+T_PW+T_H+1 cycles after accept edge
//   (10 with defaults). Poll read k starts (k-1)*(T_AS+T_PW+T_H+T_GAP) later.
//  Read counter width $clog2(POLL_MAX+1); timing counter sized for max(T_*).
//  req high in DONE cycle ignored; new req accepted in IDLE the next cycle.
//  Reset mid-operation: abort, no done pulse, rd_data cleared.
// TESTING
//  1 rst=0 then release -> all outputs 0, rd_data=00, state IDLE, no lcd_e activity.
//  2 op=00, lcd_data_in=8'h85 -> rs=0, rw=1, lcd_e high exactly 5 cyc, done 10 cyc
//    after accept, rd_data=85, busy_flag=1, addr_cnt=05, bus_own=0 on done.
//  3 op=01, lcd_data_in=8'h20 -> rs=1 during cycle, rd_data=20, done once, timeout=0.
//  4 op=10, bus 8'h80 for 3 reads then 8'h12 -> 4 lcd_e pulses spaced 13 cyc,
//    done with addr_cnt=12, busy_flag=0, timeout=0.
//  5 op=10, bus stuck 8'h80 -> exactly 8 lcd_e pulses, done with timeout=1.
//  6 rst=0 during E_HIGH -> lcd_e=0 immediately, no done; req while busy ignored.

Source files
------------

// File: rtl/lcd_read_controller_if.sv
// Purpose : request/status and LCD read-bus bundle for lcd_read_controller.
// Latency : n/a (wires only).
// Backpressure: none; req is only honoured while the controller is idle.
// Ports   : req/op/lcd_data_in flow master->slave; status and LCD strobes flow slave->master.
interface lcd_read_controller_if;
    logic       req;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr_cnt;
    logic       timeout;
    logic       bus_own;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_in;

    modport master (
        output req, op, lcd_data_in,
        input  busy, done, rd_data, busy_flag, addr_cnt, timeout,
               bus_own, lcd_rs, lcd_rw, lcd_e
    );

    modport slave (
        input  req, op, lcd_data_in,
        output busy, done, rd_data, busy_flag, addr_cnt, timeout,
               bus_own, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_read_controller.sv
// Purpose : HD44780-style read cycles (status read, data read, poll-until-not-busy).
// Latency : single read -> done T_AS+T_PW+T_H+1 cycles after the accept edge.
// Backpressure: req ignored unless idle; one operation in flight at a time.
// Ports   : clk, rst (async active-low), bus (slave modport: req/op in, busy/done/
//           rd_data/busy_flag/addr_cnt/timeout/bus_own/lcd_rs/lcd_rw/lcd_e out, lcd_data_in in).
module lcd_read_controller #(
    parameter int T_AS     = 2,
    parameter int T_PW     = 5,
    parameter int T_H      = 2,
    parameter int T_GAP    = 4,
    parameter int POLL_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_read_controller_if.slave  bus
);

    localparam int TMAX_A = (T_AS > T_PW) ? T_AS : T_PW;
    localparam int TMAX_B = (T_H > T_GAP) ? T_H : T_GAP;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int CW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  reads_q, reads_d;
    logic [1:0]     op_q, op_d;
    logic           start_q, start_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           bus_own_q, bus_own_d;
    logic           lcd_rs_q, lcd_rs_d;
    logic           lcd_rw_q, lcd_rw_d;
    logic           lcd_e_q, lcd_e_d;

    logic           is_data;
    logic           is_poll;
    logic           finish;
    logic           finish_to;

    assign is_data = (op_q == 2'b01);
    assign is_poll = (op_q == 2'b10);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reads_d   = reads_q;
        op_d      = op_q;
        start_d   = start_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        bus_own_d = bus_own_q;
        lcd_rs_d  = lcd_rs_q;
        lcd_rw_d  = lcd_rw_q;
        lcd_e_d   = lcd_e_q;
        finish    = 1'b0;
        finish_to = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // Accept edge only latches op; SETUP becomes visible one edge later,
                // and req during that pending cycle is ignored.
                if (start_q) begin
                    start_d   = 1'b0;
                    state_d   = S_SETUP;
                    cnt_d     = CW'(T_AS - 1);
                    reads_d   = '0;
                    busy_d    = 1'b1;
                    bus_own_d = 1'b1;
                    lcd_rw_d  = 1'b1;
                    lcd_rs_d  = is_data;
                    lcd_e_d   = 1'b0;
                end else if (bus.req) begin
                    start_d = 1'b1;
                    op_d    = bus.op;
                end
            end

            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_E_HIGH;
                    cnt_d   = CW'(T_PW - 1);
                    lcd_e_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_E_HIGH: begin
                if (cnt_q == '0) begin
                    // Sample on the same edge that drops lcd_e.
                    state_d   = S_HOLD;
                    cnt_d     = CW'(T_H - 1);
                    lcd_e_d   = 1'b0;
                    rd_data_d = bus.lcd_data_in;
                    reads_d   = reads_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (is_poll && rd_data_q[7]) begin
                        if (reads_q == RW'(POLL_MAX)) begin
                            finish    = 1'b1;
                            finish_to = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = CW'(T_GAP - 1);
                        end
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_GAP: begin
                // Bus stays owned with rw=1 between polls so the write side cannot sneak in.
                if (cnt_q == '0) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_AS - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = finish_to;
            bus_own_d = 1'b0;
            lcd_rw_d  = 1'b0;
            lcd_rs_d  = 1'b0;
            lcd_e_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            reads_q   <= '0;
            op_q      <= 2'b00;
            start_q   <= 1'b0;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            bus_own_q <= 1'b0;
            lcd_rs_q  <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_e_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reads_q   <= reads_d;
            op_q      <= op_d;
            start_q   <= start_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            bus_own_q <= bus_own_d;
            lcd_rs_q  <= lcd_rs_d;
            lcd_rw_q  <= lcd_rw_d;
            lcd_e_q   <= lcd_e_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy_flag = rd_data_q[7];
    assign bus.addr_cnt  = rd_data_q[6:0];
    assign bus.timeout   = timeout_q;
    assign bus.bus_own   = bus_own_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = lcd_rw_q;
    assign bus.lcd_e     = lcd_e_q;

endmodule

// File: tb/tb_lcd_read_controller.sv
// Purpose : directed, table-driven bench for lcd_read_controller.
// Latency : n/a.
// Backpressure: n/a.
module tb_lcd_read_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lcd_read_controller_if bus_if();

    lcd_read_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        int         nb;       // number of reads that see 8'h80 before fin appears
        logic [7:0] fin;
        int         exp_pulses;
        int         exp_lat;
        logic [7:0] exp_rd;
        logic       exp_to;
        logic       exp_rs;
    } vec_t;

    // Results gathered by run_op
    int         r_pulses, r_first_rise, r_spacing_bad, r_wmin, r_wmax;
    int         r_rs_bad, r_rw_bad, r_own_bad, r_done_lat, r_done_cnt, r_to_outside;
    logic [7:0] r_rd;
    logic [6:0] r_ac;
    logic       r_bf, r_to, r_own_done, r_rw_done, r_busy1, r_busy_after;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op_i, input int nb, input logic [7:0] fin,
                          input logic exp_rs);
        int   last_rise;
        int   wcur;
        logic prev_e;
        r_pulses = 0; r_first_rise = -1; r_spacing_bad = 0; r_wmin = 999; r_wmax = 0;
        r_rs_bad = 0; r_rw_bad = 0; r_own_bad = 0; r_done_lat = -1; r_done_cnt = 0;
        r_to_outside = 0; r_rd = 8'h00; r_ac = 7'h00; r_bf = 1'b0; r_to = 1'b0;
        r_own_done = 1'b1; r_rw_done = 1'b1; r_busy1 = 1'b0; r_busy_after = 1'b1;
        bus_if.op          = op_i;
        bus_if.req         = 1'b1;
        bus_if.lcd_data_in = (nb > 0) ? 8'h80 : fin;
        tick;                       // accept edge
        bus_if.req = 1'b0;
        prev_e     = 1'b0;
        last_rise  = -1;
        wcur       = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            tick;
            if (cyc == 1) r_busy1 = bus_if.busy;
            if (bus_if.lcd_e && !prev_e) begin
                r_pulses++;
                if (r_pulses == 1) r_first_rise = cyc;
                else if (cyc - last_rise != 13) r_spacing_bad++;
                last_rise = cyc;
                bus_if.lcd_data_in = (r_pulses <= nb) ? 8'h80 : fin;
                wcur = 0;
            end
            if (bus_if.lcd_e) begin
                wcur++;
                if (bus_if.lcd_rs !== exp_rs) r_rs_bad++;
                if (bus_if.lcd_rw !== 1'b1)   r_rw_bad++;
                if (bus_if.bus_own !== 1'b1)  r_own_bad++;
            end
            if (!bus_if.lcd_e && prev_e) begin
                if (wcur < r_wmin) r_wmin = wcur;
                if (wcur > r_wmax) r_wmax = wcur;
            end
            prev_e = bus_if.lcd_e;
            if (bus_if.timeout && !bus_if.done) r_to_outside++;
            if (bus_if.done) begin
                r_done_cnt++;
                if (r_done_lat < 0) begin
                    r_done_lat = cyc;
                    r_rd       = bus_if.rd_data;
                    r_bf       = bus_if.busy_flag;
                    r_ac       = bus_if.addr_cnt;
                    r_to       = bus_if.timeout;
                    r_own_done = bus_if.bus_own;
                    r_rw_done  = bus_if.lcd_rw;
                end
            end
            if (r_done_lat >= 0 && cyc == r_done_lat + 1) r_busy_after = bus_if.busy;
            if (r_done_lat >= 0 && cyc >= r_done_lat + 3) break;
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b00, 0,  8'h85, 1, 10,  8'h85, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 0,  8'h20, 1, 10,  8'h20, 1'b0, 1'b1};
        vecs[2] = '{2'b11, 0,  8'h3C, 1, 10,  8'h3C, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 0,  8'hFF, 1, 10,  8'hFF, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 3,  8'h12, 4, 49,  8'h12, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 0,  8'h05, 1, 10,  8'h05, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 99, 8'h80, 8, 101, 8'h80, 1'b1, 1'b0};
        vecs[7] = '{2'b00, 0,  8'h00, 1, 10,  8'h00, 1'b0, 1'b0};

        bus_if.req         = 1'b0;
        bus_if.op          = 2'b00;
        bus_if.lcd_data_in = 8'h00;

        // Reset state
        rst = 1'b0;
        repeat (3) tick;
        chk("rst_busy",    {31'd0, bus_if.busy},    0);
        chk("rst_done",    {31'd0, bus_if.done},    0);
        chk("rst_timeout", {31'd0, bus_if.timeout}, 0);
        chk("rst_bus_own", {31'd0, bus_if.bus_own}, 0);
        chk("rst_lcd_rs",  {31'd0, bus_if.lcd_rs},  0);
        chk("rst_lcd_rw",  {31'd0, bus_if.lcd_rw},  0);
        chk("rst_lcd_e",   {31'd0, bus_if.lcd_e},   0);
        chk("rst_rd_data", {24'd0, bus_if.rd_data}, 0);
        rst = 1'b1;
        begin
            int act = 0;
            for (int i = 0; i < 6; i++) begin
                tick;
                if (bus_if.lcd_e || bus_if.busy || bus_if.bus_own) act++;
            end
            chk("post_rst_idle_activity", act, 0);
        end

        // Table-driven operations
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].op, vecs[v].nb, vecs[v].fin, vecs[v].exp_rs);
            $display("vector %0d op=%0d", v, vecs[v].op);
            chk("done_latency",  r_done_lat,    vecs[v].exp_lat);
            chk("e_pulses",      r_pulses,      vecs[v].exp_pulses);
            chk("first_e_rise",  r_first_rise,  3);
            chk("e_width_min",   r_wmin,        5);
            chk("e_width_max",   r_wmax,        5);
            chk("e_spacing_bad", r_spacing_bad, 0);
            chk("rs_during_e",   r_rs_bad,      0);
            chk("rw_during_e",   r_rw_bad,      0);
            chk("own_during_e",  r_own_bad,     0);
            chk("rd_data",       {24'd0, r_rd}, {24'd0, vecs[v].exp_rd});
            chk("busy_flag",     {31'd0, r_bf}, {31'd0, vecs[v].exp_rd[7]});
            chk("addr_cnt",      {25'd0, r_ac}, {25'd0, vecs[v].exp_rd[6:0]});
            chk("timeout",       {31'd0, r_to}, {31'd0, vecs[v].exp_to});
            chk("own_at_done",   {31'd0, r_own_done}, 0);
            chk("rw_at_done",    {31'd0, r_rw_done},  0);
            chk("done_count",    r_done_cnt,    1);
            chk("timeout_stray", r_to_outside,  0);
            chk("busy_cycle1",   {31'd0, r_busy1},      1);
            chk("busy_after",    {31'd0, r_busy_after}, 0);
            tick;
        end

        // req held through the op (ignored), through DONE (ignored), then accepted in IDLE
        begin
            int   dl  = -1;
            int   rsb = 0;
            bus_if.op          = 2'b01;
            bus_if.lcd_data_in = 8'h20;
            bus_if.req         = 1'b1;
            tick;                   // accept edge
            bus_if.op = 2'b10;      // must not disturb the running data read
            for (int cyc = 1; cyc <= 20; cyc++) begin
                tick;
                if (bus_if.lcd_e && bus_if.lcd_rs !== 1'b1) rsb++;
                if (bus_if.done) begin
                    dl = cyc;
                    break;
                end
            end
            chk("hold_req_done_lat", dl, 10);
            chk("hold_req_rs",       rsb, 0);
            tick;                   // DONE -> IDLE, req ignored
            chk("done_req_ignored_busy", {31'd0, bus_if.busy}, 0);
            chk("done_req_no_repeat",    {31'd0, bus_if.done}, 0);
            tick;                   // IDLE accepts
            chk("accept_edge_busy", {31'd0, bus_if.busy}, 0);
            bus_if.req = 1'b0;
            tick;
            chk("next_op_busy", {31'd0, bus_if.busy},    1);
            chk("next_op_own",  {31'd0, bus_if.bus_own}, 1);
            chk("next_op_rs",   {31'd0, bus_if.lcd_rs},  0);
            dl = -1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                tick;
                if (bus_if.done) begin
                    dl = cyc;
                    break;
                end
            end
            chk("next_op_done_seen", {31'd0, (dl > 0)}, 1);
            chk("next_op_rd",        {24'd0, bus_if.rd_data}, 32'h20);
            chk("next_op_timeout",   {31'd0, bus_if.timeout}, 0);
            repeat (2) tick;
        end

        // Reset during E_HIGH
        begin
            int dcnt = 0;
            int ecnt = 0;
            bus_if.op          = 2'b00;
            bus_if.lcd_data_in = 8'h85;
            bus_if.req         = 1'b1;
            tick;
            bus_if.req = 1'b0;
            repeat (4) tick;
            chk("pre_rst_e_high", {31'd0, bus_if.lcd_e}, 1);
            rst = 1'b0;
            #1;
            chk("mid_rst_e",       {31'd0, bus_if.lcd_e},   0);
            chk("mid_rst_busy",    {31'd0, bus_if.busy},    0);
            chk("mid_rst_own",     {31'd0, bus_if.bus_own}, 0);
            chk("mid_rst_rw",      {31'd0, bus_if.lcd_rw},  0);
            chk("mid_rst_rd_data", {24'd0, bus_if.rd_data}, 0);
            repeat (2) tick;
            rst = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick;
                if (bus_if.done)  dcnt++;
                if (bus_if.lcd_e) ecnt++;
            end
            chk("abort_no_done", dcnt, 0);
            chk("abort_no_e",    ecnt, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
